// File: rtl/instr_router_pkg.sv
// -----------------------------------------------------------------------------
// instr_router_pkg
// Shared types and helpers for the instruction region router:
//   MAX_REGIONS   - largest supported number of target regions
//   CFG_AW        - width of the region configuration fields (covers any
//                   supported fetch address width)
//   region_cfg_t  - one region's base/mask pair
//   err_id()      - FIFO tag used for fetches that hit no region
//   id_width()    - tag width able to hold every region index plus err_id()
//   make_cfg()    - builds a region_cfg_t from base/mask values
//   cfg_match()   - region hit test: (addr & mask) == base
// -----------------------------------------------------------------------------
package instr_router_pkg;

    localparam int unsigned MAX_REGIONS = 8;
    localparam int unsigned CFG_AW      = 64;

    typedef struct packed {
        logic [CFG_AW-1:0] base;
        logic [CFG_AW-1:0] mask;
    } region_cfg_t;

    // Unmapped fetches are tagged with the first index past the real regions.
    function automatic int unsigned err_id(input int unsigned num_regions);
        return num_regions;
    endfunction

    function automatic int unsigned id_width(input int unsigned num_regions);
        return $clog2(num_regions + 32'd1);
    endfunction

    function automatic region_cfg_t make_cfg(input logic [CFG_AW-1:0] base,
                                             input logic [CFG_AW-1:0] mask);
        region_cfg_t cfg;
        cfg.base = base;
        cfg.mask = mask;
        return cfg;
    endfunction

    function automatic logic cfg_match(input region_cfg_t       cfg,
                                       input logic [CFG_AW-1:0] addr);
        return ((addr & cfg.mask) == cfg.base);
    endfunction

endpackage

// File: rtl/instr_router_id_fifo.sv
// -----------------------------------------------------------------------------
// instr_router_id_fifo
// Small FIFO of target tags for fetches that were granted but not yet
// answered. Occupancy is held in a counter so that "full" and "empty" are
// pure functions of registered state.
// Ports:
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   push_i, push_id_i  - write a tag (ignored while full)
//   pop_i              - drop the head tag (ignored while empty)
//   full_o, empty_o    - registered occupancy flags
//   head_id_o          - tag at the head (zero while empty)
// -----------------------------------------------------------------------------
module instr_router_id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_id_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_id_o
);

    localparam int unsigned PTR_W = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 32'd1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 32'd1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s;
    logic             pop_s;

    // Flags come only from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == {CNT_W{1'b0}});

    // Head tag, forced to zero while empty.
    always_comb begin
        head_id_o = {WIDTH{1'b0}};
        if (!empty_o) begin
            head_id_o = mem_q[rd_ptr_q];
        end else begin
            head_id_o = {WIDTH{1'b0}};
        end
    end

    // Next-state for storage, pointers (wrap at DEPTH) and occupancy.
    always_comb begin
        push_s   = push_i && !full_o;
        pop_s    = pop_i && !empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_region_router.sv
// -----------------------------------------------------------------------------
// instr_region_router
// Routes core instruction fetches to one of NUM_REGIONS targets by address
// decode and returns responses to the core strictly in grant order.
// Fetches that hit no region are granted locally and answered with an error.
// Ports:
//   clk_i, rst_ni                    - clock, asynchronous active-low reset
//   core_instr_req_i/gnt_o/addr_i    - core request channel
//   core_instr_rvalid_o/rdata_o/err_o- core response channel (zero when idle)
//   tgt_req_o/gnt_i/addr_o           - per-region request channels
//   tgt_rvalid_i/rdata_i/err_i       - per-region response channels
//   resp_violation_o                 - sticky: a target answered out of turn
// -----------------------------------------------------------------------------
module instr_region_router
    import instr_router_pkg::*;
#(
    parameter int unsigned NUM_REGIONS     = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] REGION_BASE [NUM_REGIONS] = '{32'h00040000, 32'h00000000},
    parameter logic [ADDR_WIDTH-1:0] REGION_MASK [NUM_REGIONS] = '{32'hFFFFFF00, 32'hFFFFFC00},
    parameter bit STRIP_BASE = 1'b1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  core_instr_req_i,
    output logic                                  core_instr_gnt_o,
    output logic                                  core_instr_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]                 core_instr_addr_i,
    output logic [DATA_WIDTH-1:0]                 core_instr_rdata_o,
    output logic                                  core_instr_err_o,
    output logic [NUM_REGIONS-1:0]                tgt_req_o,
    input  logic [NUM_REGIONS-1:0]                tgt_gnt_i,
    input  logic [NUM_REGIONS-1:0]                tgt_rvalid_i,
    output logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] tgt_addr_o,
    input  logic [NUM_REGIONS-1:0][DATA_WIDTH-1:0] tgt_rdata_i,
    input  logic [NUM_REGIONS-1:0]                tgt_err_i,
    output logic                                  resp_violation_o
);

    localparam int unsigned ID_W = id_width(NUM_REGIONS);
    localparam logic [ID_W-1:0] ERR_IDX = ID_W'(err_id(NUM_REGIONS));

    // Elaboration-time parameter range checks.
    if ((NUM_REGIONS == 32'd0) || (NUM_REGIONS > MAX_REGIONS)) begin : g_chk_regions
        $error("instr_region_router: NUM_REGIONS must be 1..8");
    end
    if ((MAX_OUTSTANDING == 32'd0) || (MAX_OUTSTANDING > 32'd8)) begin : g_chk_outstanding
        $error("instr_region_router: MAX_OUTSTANDING must be 1..8");
    end
    if ((ADDR_WIDTH == 32'd0) || (ADDR_WIDTH > CFG_AW)) begin : g_chk_addr
        $error("instr_region_router: ADDR_WIDTH must be 1..64");
    end

    logic [NUM_REGIONS-1:0] hit_s;
    logic [ID_W-1:0]        sel_s;
    logic                   mapped_s;
    logic                   sel_gnt_s;
    logic                   accept_s;
    logic [ID_W-1:0]        push_id_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [ID_W-1:0]        head_id_s;
    logic                   head_is_err_s;
    logic                   head_rvalid_s;
    logic [DATA_WIDTH-1:0]  head_rdata_s;
    logic                   head_err_s;
    logic                   pop_s;
    logic                   stray_s;
    logic                   resp_violation_q, resp_violation_d;

    // Address decode: hit vector, then lowest hitting index wins.
    always_comb begin
        hit_s    = '0;
        sel_s    = {ID_W{1'b0}};
        mapped_s = 1'b0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            hit_s[i] = cfg_match(make_cfg(CFG_AW'(REGION_BASE[i]), CFG_AW'(REGION_MASK[i])),
                                 CFG_AW'(core_instr_addr_i));
        end
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (hit_s[i] && !mapped_s) begin
                sel_s    = ID_W'(i);
                mapped_s = 1'b1;
            end else begin
                sel_s    = sel_s;
                mapped_s = mapped_s;
            end
        end
    end

    // Request side: forward the request to the selected region and return its
    // grant; unmapped fetches are granted locally. Nothing is granted while
    // full or while reset is asserted.
    always_comb begin
        sel_gnt_s = 1'b0;
        tgt_req_o = '0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            sel_gnt_s    = (sel_s == ID_W'(i)) ? tgt_gnt_i[i] : sel_gnt_s;
            tgt_req_o[i] = rst_ni && core_instr_req_i && mapped_s &&
                           (sel_s == ID_W'(i)) && !fifo_full_s;
        end
        core_instr_gnt_o = rst_ni && !fifo_full_s && (mapped_s ? sel_gnt_s : 1'b1);
        accept_s         = core_instr_req_i && core_instr_gnt_o;
        push_id_s        = mapped_s ? sel_s : ERR_IDX;
    end

    // Target address: offset within the region, or the full address.
    always_comb begin
        tgt_addr_o = '0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (STRIP_BASE) begin
                tgt_addr_o[i] = core_instr_addr_i & ~REGION_MASK[i];
            end else begin
                tgt_addr_o[i] = core_instr_addr_i;
            end
        end
    end

    instr_router_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_W)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (accept_s),
        .push_id_i (push_id_s),
        .pop_i     (pop_s),
        .full_o    (fifo_full_s),
        .empty_o   (fifo_empty_s),
        .head_id_o (head_id_s)
    );

    // Response side: the head tag picks the only target allowed to answer.
    // An error-tagged head answers by itself; it is only ever head from the
    // cycle after its grant because the tag is read from registered storage.
    always_comb begin
        head_rvalid_s = 1'b0;
        head_rdata_s  = {DATA_WIDTH{1'b0}};
        head_err_s    = 1'b0;
        stray_s       = 1'b0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            head_rvalid_s = (head_id_s == ID_W'(i)) ? tgt_rvalid_i[i] : head_rvalid_s;
            head_rdata_s  = (head_id_s == ID_W'(i)) ? tgt_rdata_i[i]  : head_rdata_s;
            head_err_s    = (head_id_s == ID_W'(i)) ? tgt_err_i[i]    : head_err_s;
            stray_s       = stray_s || (tgt_rvalid_i[i] &&
                                        (fifo_empty_s || (head_id_s != ID_W'(i))));
        end
        head_is_err_s       = !fifo_empty_s && (head_id_s == ERR_IDX);
        core_instr_rvalid_o = !fifo_empty_s && (head_is_err_s || head_rvalid_s);
        if (core_instr_rvalid_o && !head_is_err_s) begin
            core_instr_rdata_o = head_rdata_s;
            core_instr_err_o   = head_err_s;
        end else if (core_instr_rvalid_o) begin
            core_instr_rdata_o = {DATA_WIDTH{1'b0}};
            core_instr_err_o   = 1'b1;
        end else begin
            core_instr_rdata_o = {DATA_WIDTH{1'b0}};
            core_instr_err_o   = 1'b0;
        end
        pop_s            = core_instr_rvalid_o;
        resp_violation_d = resp_violation_q || stray_s;
    end

    // Sticky out-of-order response flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_violation_q <= 1'b0;
        end else begin
            resp_violation_q <= resp_violation_d;
        end
    end

    assign resp_violation_o = resp_violation_q;

endmodule

// File: tb/tb_instr_region_router.sv
module tb_instr_region_router;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       addr;
    logic [31:0]       rdata;
    logic              err;
    logic [1:0]        tgt_req;
    logic [1:0]        tgt_gnt;
    logic [1:0]        tgt_rvalid;
    logic [1:0][31:0]  tgt_addr;
    logic [1:0][31:0]  tgt_rdata;
    logic [1:0]        tgt_err;
    logic              viol;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          region;
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    always #5 clk = ~clk;

    instr_region_router dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .core_instr_req_i    (req),
        .core_instr_gnt_o    (gnt),
        .core_instr_rvalid_o (rvalid),
        .core_instr_addr_i   (addr),
        .core_instr_rdata_o  (rdata),
        .core_instr_err_o    (err),
        .tgt_req_o           (tgt_req),
        .tgt_gnt_i           (tgt_gnt),
        .tgt_rvalid_i        (tgt_rvalid),
        .tgt_addr_o          (tgt_addr),
        .tgt_rdata_i         (tgt_rdata),
        .tgt_err_i           (tgt_err),
        .resp_violation_o    (viol)
    );

    // Reference decode: 0 = ROM (0x00040000/0xFFFFFF00), 1 = RAM (0/0xFFFFFC00), 2 = unmapped
    function automatic int decode(input logic [31:0] a);
        if ((a & 32'hFFFFFF00) == 32'h00040000) return 0;
        else if ((a & 32'hFFFFFC00) == 32'h00000000) return 1;
        else return 2;
    endfunction

    task automatic idle();
        req        = 1'b0;
        addr       = 32'h0;
        tgt_gnt    = 2'b00;
        tgt_rvalid = 2'b00;
        tgt_rdata  = '0;
        tgt_err    = 2'b00;
    endtask

    // Drive point: just after the active edge.
    task automatic drive_point();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_point();
        idle();
        rst_n = 1'b0;
        drive_point();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_point();
        rst_n = 1'b0;
        idle();
        req = 1'b1; addr = 32'h10; tgt_gnt = 2'b11; tgt_rvalid = 2'b11;
        tgt_rdata[0] = 32'hDEAD0000; tgt_rdata[1] = 32'hDEAD0001; tgt_err = 2'b11;
        #4;
        tests++; if (tgt_req !== 2'b00) begin $display("FAIL reset_tgt_req got %b exp 00", tgt_req); fails++; end
        tests++; if (gnt !== 1'b0) begin $display("FAIL reset_gnt got %b exp 0", gnt); fails++; end
        tests++; if (rvalid !== 1'b0) begin $display("FAIL reset_rvalid got %b exp 0", rvalid); fails++; end
        tests++; if (rdata !== 32'h0) begin $display("FAIL reset_rdata got %h exp 0", rdata); fails++; end
        tests++; if (err !== 1'b0) begin $display("FAIL reset_err got %b exp 0", err); fails++; end
        tests++; if (viol !== 1'b0) begin $display("FAIL reset_viol got %b exp 0", viol); fails++; end
        drive_point();
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        drive_point();
        idle(); req = 1'b1; addr = 32'h00000010; tgt_gnt = 2'b10;
        #4;
        tests++; if (tgt_req !== 2'b10) begin $display("FAIL single_tgt_req got %b exp 10", tgt_req); fails++; end
        tests++; if (gnt !== 1'b1) begin $display("FAIL single_gnt got %b exp 1", gnt); fails++; end
        tests++; if (tgt_addr[1] !== 32'h10) begin $display("FAIL single_tgt_addr1 got %h exp 10", tgt_addr[1]); fails++; end
        tests++; if (rvalid !== 1'b0) begin $display("FAIL single_rvalid_early got %b exp 0", rvalid); fails++; end
        drive_point();
        idle(); tgt_rvalid = 2'b10; tgt_rdata[1] = 32'h00000013;
        #4;
        tests++; if (rvalid !== 1'b1) begin $display("FAIL single_rvalid got %b exp 1", rvalid); fails++; end
        tests++; if (rdata !== 32'h00000013) begin $display("FAIL single_rdata got %h exp 13", rdata); fails++; end
        tests++; if (err !== 1'b0) begin $display("FAIL single_err got %b exp 0", err); fails++; end
        drive_point();
        idle();
        #4;
        tests++; if (rvalid !== 1'b0) begin $display("FAIL single_rvalid_after got %b exp 0", rvalid); fails++; end
    endtask

    task automatic test_decode_boundaries();
        logic [31:0] vec_addr [4];
        logic [1:0]  vec_req  [4];
        logic [31:0] vec_off0 [4];
        vec_addr = '{32'h000003FC, 32'h00000400, 32'h000400FF, 32'h00040100};
        vec_req  = '{2'b10, 2'b00, 2'b01, 2'b00};
        vec_off0 = '{32'h000000FC, 32'h00000000, 32'h000000FF, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            drive_point();
            idle(); addr = vec_addr[i];
            // Mapped: request with no target grant. Unmapped: no request, grant seen anyway.
            req = (vec_req[i] != 2'b00);
            #4;
            tests++; if (tgt_req !== vec_req[i]) begin $display("FAIL bound_tgt_req[%0d] got %b exp %b", i, tgt_req, vec_req[i]); fails++; end
            tests++; if (gnt !== (vec_req[i] == 2'b00)) begin $display("FAIL bound_gnt[%0d] got %b exp %b", i, gnt, (vec_req[i] == 2'b00)); fails++; end
            tests++; if (tgt_addr[0] !== vec_off0[i]) begin $display("FAIL bound_addr0[%0d] got %h exp %h", i, tgt_addr[0], vec_off0[i]); fails++; end
        end
        drive_point();
        idle();
    endtask

    task automatic test_unmapped();
        drive_point();
        idle(); req = 1'b1; addr = 32'h80000000;
        #4;
        tests++; if (gnt !== 1'b1) begin $display("FAIL unmap_gnt got %b exp 1", gnt); fails++; end
        tests++; if (tgt_req !== 2'b00) begin $display("FAIL unmap_tgt_req got %b exp 00", tgt_req); fails++; end
        tests++; if (rvalid !== 1'b0) begin $display("FAIL unmap_rvalid_early got %b exp 0", rvalid); fails++; end
        drive_point();
        idle();
        #4;
        tests++; if (rvalid !== 1'b1) begin $display("FAIL unmap_rvalid got %b exp 1", rvalid); fails++; end
        tests++; if (err !== 1'b1) begin $display("FAIL unmap_err got %b exp 1", err); fails++; end
        tests++; if (rdata !== 32'h0) begin $display("FAIL unmap_rdata got %h exp 0", rdata); fails++; end
        drive_point();
        #4;
        tests++; if (rvalid !== 1'b0) begin $display("FAIL unmap_rvalid_after got %b exp 0", rvalid); fails++; end
    endtask

    task automatic test_out_of_order();
        drive_point();
        idle(); req = 1'b1; addr = 32'h00040080; tgt_gnt = 2'b01;
        #4;
        tests++; if (tgt_req !== 2'b01) begin $display("FAIL ooo_tgt_req0 got %b exp 01", tgt_req); fails++; end
        tests++; if (tgt_addr[0] !== 32'h80) begin $display("FAIL ooo_addr0 got %h exp 80", tgt_addr[0]); fails++; end
        drive_point();
        idle(); req = 1'b1; addr = 32'h00000004; tgt_gnt = 2'b10;
        #4;
        tests++; if (gnt !== 1'b1) begin $display("FAIL ooo_gnt1 got %b exp 1", gnt); fails++; end
        drive_point();
        idle(); tgt_rvalid = 2'b10; tgt_rdata[1] = 32'h00000022;
        #4;
        tests++; if (rvalid !== 1'b0) begin $display("FAIL ooo_drop got %b exp 0", rvalid); fails++; end
        drive_point();
        idle(); tgt_rvalid = 2'b01; tgt_rdata[0] = 32'h00000011;
        #4;
        tests++; if (viol !== 1'b1) begin $display("FAIL ooo_viol got %b exp 1", viol); fails++; end
        tests++; if (rdata !== 32'h11 || rvalid !== 1'b1) begin $display("FAIL ooo_rom got %b/%h exp 1/11", rvalid, rdata); fails++; end
        drive_point();
        idle(); tgt_rvalid = 2'b10; tgt_rdata[1] = 32'h00000022;
        #4;
        tests++; if (rdata !== 32'h22 || rvalid !== 1'b1) begin $display("FAIL ooo_ram got %b/%h exp 1/22", rvalid, rdata); fails++; end
        drive_point();
        idle();
        #4;
        tests++; if (viol !== 1'b1) begin $display("FAIL ooo_sticky got %b exp 1", viol); fails++; end
    endtask

    task automatic test_correct_order();
        drive_point();
        idle(); req = 1'b1; addr = 32'h00040080; tgt_gnt = 2'b01;
        drive_point();
        idle(); req = 1'b1; addr = 32'h00000004; tgt_gnt = 2'b10;
        drive_point();
        idle(); tgt_rvalid = 2'b01; tgt_rdata[0] = 32'h0000A011; tgt_err = 2'b01;
        #4;
        tests++; if (rvalid !== 1'b1 || rdata !== 32'h0000A011) begin $display("FAIL order_rom got %b/%h exp 1/a011", rvalid, rdata); fails++; end
        tests++; if (err !== 1'b1) begin $display("FAIL order_rom_err got %b exp 1", err); fails++; end
        drive_point();
        idle(); tgt_rvalid = 2'b10; tgt_rdata[1] = 32'h0000B022;
        #4;
        tests++; if (rvalid !== 1'b1 || rdata !== 32'h0000B022) begin $display("FAIL order_ram got %b/%h exp 1/b022", rvalid, rdata); fails++; end
        tests++; if (err !== 1'b0) begin $display("FAIL order_ram_err got %b exp 0", err); fails++; end
        drive_point();
        idle();
        #4;
        tests++; if (viol !== 1'b0) begin $display("FAIL order_viol got %b exp 0", viol); fails++; end
    endtask

    task automatic test_full();
        drive_point();
        idle(); req = 1'b1; addr = 32'h10; tgt_gnt = 2'b10;
        drive_point();
        idle(); req = 1'b1; addr = 32'h20; tgt_gnt = 2'b10;
        #4;
        tests++; if (gnt !== 1'b1) begin $display("FAIL full_second_gnt got %b exp 1", gnt); fails++; end
        drive_point();
        idle(); req = 1'b1; addr = 32'h30; tgt_gnt = 2'b11;
        #4;
        tests++; if (gnt !== 1'b0) begin $display("FAIL full_gnt got %b exp 0", gnt); fails++; end
        tests++; if (tgt_req !== 2'b00) begin $display("FAIL full_tgt_req got %b exp 00", tgt_req); fails++; end
        drive_point();
        idle(); req = 1'b1; addr = 32'h30; tgt_gnt = 2'b11; tgt_rvalid = 2'b10; tgt_rdata[1] = 32'h111;
        #4;
        tests++; if (rvalid !== 1'b1 || rdata !== 32'h111) begin $display("FAIL full_pop got %b/%h exp 1/111", rvalid, rdata); fails++; end
        tests++; if (gnt !== 1'b0) begin $display("FAIL full_pop_gnt got %b exp 0", gnt); fails++; end
        drive_point();
        idle(); req = 1'b1; addr = 32'h30; tgt_gnt = 2'b11;
        #4;
        tests++; if (gnt !== 1'b1) begin $display("FAIL full_freed_gnt got %b exp 1", gnt); fails++; end
        tests++; if (tgt_req !== 2'b10) begin $display("FAIL full_freed_req got %b exp 10", tgt_req); fails++; end
        drive_point();
        idle(); tgt_rvalid = 2'b10; tgt_rdata[1] = 32'h222;
        #4;
        tests++; if (rvalid !== 1'b1 || rdata !== 32'h222) begin $display("FAIL full_r2 got %b/%h exp 1/222", rvalid, rdata); fails++; end
        drive_point();
        idle(); tgt_rvalid = 2'b10; tgt_rdata[1] = 32'h333;
        #4;
        tests++; if (rvalid !== 1'b1 || rdata !== 32'h333) begin $display("FAIL full_r3 got %b/%h exp 1/333", rvalid, rdata); fails++; end
        drive_point();
        idle();
        #4;
        tests++; if (rvalid !== 1'b0 || viol !== 1'b0) begin $display("FAIL full_drained got %b/%b exp 0/0", rvalid, viol); fails++; end
    endtask

    task automatic test_reset_mid();
        drive_point();
        idle(); req = 1'b1; addr = 32'h10; tgt_gnt = 2'b10;
        drive_point();
        idle(); req = 1'b1; addr = 32'h00040080; tgt_gnt = 2'b01;
        drive_point();
        idle(); rst_n = 1'b0; req = 1'b1; addr = 32'h10; tgt_gnt = 2'b11;
        tgt_rvalid = 2'b10; tgt_rdata[1] = 32'h55; tgt_err = 2'b10;
        #4;
        tests++; if (tgt_req !== 2'b00) begin $display("FAIL mid_tgt_req got %b exp 00", tgt_req); fails++; end
        tests++; if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin $display("FAIL mid_resp got %b/%b/%h exp 0/0/0", rvalid, err, rdata); fails++; end
        tests++; if (viol !== 1'b0) begin $display("FAIL mid_viol got %b exp 0", viol); fails++; end
        drive_point();
        idle(); rst_n = 1'b1;
        drive_point();
        idle(); req = 1'b1; addr = 32'h10; tgt_gnt = 2'b10;
        #4;
        tests++; if (gnt !== 1'b1) begin $display("FAIL mid_post_gnt got %b exp 1", gnt); fails++; end
        drive_point();
        idle(); tgt_rvalid = 2'b10; tgt_rdata[1] = 32'h66;
        #4;
        tests++; if (rvalid !== 1'b1 || rdata !== 32'h66) begin $display("FAIL mid_post_resp got %b/%h exp 1/66", rvalid, rdata); fails++; end
        tests++; if (viol !== 1'b0) begin $display("FAIL mid_post_viol got %b exp 0", viol); fails++; end
        drive_point();
        idle(); tgt_rvalid = 2'b01; tgt_rdata[0] = 32'h77;
        #4;
        tests++; if (rvalid !== 1'b0) begin $display("FAIL mid_late_drop got %b exp 0", rvalid); fails++; end
        drive_point();
        idle();
        #4;
        tests++; if (viol !== 1'b1) begin $display("FAIL mid_late_viol got %b exp 1", viol); fails++; end
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        int          cyc      = 0;
        int          issued   = 0;
        int          done     = 0;
        logic        have_req = 1'b0;
        logic [31:0] cur_addr = 32'h0;
        int          reg_idx;
        int          k;
        logic        full_m;
        logic        exp_rv;
        logic        exp_gnt;
        logic [1:0]  exp_treq;
        while (done < 1000 && cyc < 30000) begin
            drive_point();
            if (!have_req && issued < 1000 && $urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, 4);
                if (k < 2)       cur_addr = 32'h00040000 | {24'h0, 8'($urandom)};
                else if (k < 4)  cur_addr = {22'h0, 10'($urandom)};
                else             cur_addr = 32'h80000000 | {16'h0, 16'($urandom)};
                have_req = 1'b1;
            end
            reg_idx    = decode(cur_addr);
            req        = have_req;
            addr       = cur_addr;
            tgt_gnt    = 2'($urandom_range(0, 3));
            tgt_rvalid = 2'b00;
            tgt_rdata  = '0;
            tgt_err    = 2'b00;
            if (q.size() > 0 && q[0].region < 2 && q[0].acc < cyc && $urandom_range(0, 2) == 0) begin
                tgt_rvalid[q[0].region] = 1'b1;
                tgt_rdata[q[0].region]  = q[0].data;
                tgt_err[q[0].region]    = q[0].err;
            end
            #4;
            full_m   = (q.size() == 2);
            exp_rv   = (q.size() > 0) && ((q[0].region == 2) || tgt_rvalid[q[0].region]);
            exp_gnt  = !full_m && ((reg_idx == 2) ? 1'b1 : tgt_gnt[reg_idx]);
            exp_treq = (have_req && !full_m && reg_idx < 2) ? 2'(1 << reg_idx) : 2'b00;
            tests++; if (rvalid !== exp_rv) begin $display("FAIL rand_rvalid cyc %0d got %b exp %b", cyc, rvalid, exp_rv); fails++; end
            if (exp_rv) begin
                e = q.pop_front();
                done++;
                tests++; if (rdata !== e.data || err !== e.err) begin $display("FAIL rand_resp cyc %0d got %h/%b exp %h/%b", cyc, rdata, err, e.data, e.err); fails++; end
            end
            tests++; if (gnt !== exp_gnt) begin $display("FAIL rand_gnt cyc %0d got %b exp %b", cyc, gnt, exp_gnt); fails++; end
            tests++; if (tgt_req !== exp_treq) begin $display("FAIL rand_tgt_req cyc %0d got %b exp %b", cyc, tgt_req, exp_treq); fails++; end
            if (have_req && exp_gnt) begin
                e.region = reg_idx;
                e.acc    = cyc;
                e.data   = (reg_idx == 2) ? 32'h0 : $urandom;
                e.err    = (reg_idx == 2) ? 1'b1 : ($urandom_range(0, 7) == 0);
                q.push_back(e);
                issued++;
                have_req = 1'b0;
            end
            cyc++;
        end
        tests++; if (done != 1000) begin $display("FAIL rand_timeout completed %0d exp 1000", done); fails++; end
        tests++; if (viol !== 1'b0) begin $display("FAIL rand_viol got %b exp 0", viol); fails++; end
        drive_point();
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_single_fetch();
        test_decode_boundaries();
        test_unmapped();
        test_out_of_order();
        do_reset();
        test_correct_order();
        test_full();
        test_reset_mid();
        do_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_region_router.md
INSTR_REGION_ROUTER -- requirements
Module: instr_region_router

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 2, number of instruction target regions (1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, fetch address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, fetch data width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, accepted-but-unanswered fetch limit (1..8).
REQ-005 SHALL have parameter REGION_BASE, default {32'h00040000, 32'h00000000}, per-region base address array.
REQ-006 SHALL have parameter REGION_MASK, default {32'hFFFFFF00, 32'hFFFFFC00}, per-region match mask array.
REQ-007 SHALL have parameter STRIP_BASE, default 1'b1; 1 = targets receive address offset (addr & ~mask).
REQ-008 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset, asynchronous, active-low.
REQ-009 SHALL have core side: core_instr_req_i in 1; core_instr_gnt_o out 1; core_instr_rvalid_o out 1; core_instr_addr_i in ADDR_WIDTH; core_instr_rdata_o out DATA_WIDTH; core_instr_err_o out 1.
REQ-010 SHALL have target side: tgt_req_o out NUM_REGIONS; tgt_gnt_i in NUM_REGIONS; tgt_rvalid_i in NUM_REGIONS; tgt_addr_o out NUM_REGIONS x ADDR_WIDTH; tgt_rdata_i in NUM_REGIONS x DATA_WIDTH; tgt_err_i in NUM_REGIONS.
REQ-011 SHALL have resp_violation_o out 1: sticky, set on out-of-order target response.

Function
REQ-012 Decode combinational: region i hits when (addr & REGION_MASK[i]) == REGION_BASE[i]; lowest index wins on overlap; no hit = unmapped.
REQ-013 tgt_req_o[i] = core_instr_req_i & hit i & ~fifo_full; all other bits 0.
REQ-014 core_instr_gnt_o = tgt_gnt_i[sel] for mapped hit, 1 for unmapped; both gated by ~fifo_full.
REQ-015 fifo_full derives only from registered occupancy (== MAX_OUTSTANDING); pop in same cycle does not free a slot that cycle.
REQ-016 On accept (req & gnt) SHALL push region index, or ERR_ID = NUM_REGIONS for unmapped, into ID FIFO.
REQ-017 Responses returned strictly in accept order; head ID selects rvalid/rdata/err source.
REQ-018 Mapped head: core_instr_rvalid_o = tgt_rvalid_i[head], rdata/err forwarded same cycle, zero added latency; pop on that rvalid.
REQ-019 ERR_ID head: rvalid_o = 1, err_o = 1, rdata_o = 0 in first cycle entry is head and at least one cycle after its accept; pop then.
REQ-020 tgt_rvalid_i[j] with j != head, or with FIFO empty, SHALL be dropped and set resp_violation_o.
REQ-021 Simultaneous push and pop SHALL keep occupancy unchanged; pointers wrap modulo MAX_OUTSTANDING.
REQ-022 core_instr_rvalid_o = 0 forces rdata_o = 0 and err_o = 0.
REQ-023 tgt_addr_o[i] = addr & ~REGION_MASK[i] when STRIP_BASE, else addr; driven to all regions.

Reset
REQ-024 While rst_ni low: FIFO empty, pointers 0, resp_violation_o 0, core_instr_rvalid_o/err_o 0, rdata_o 0, tgt_req_o 0.
REQ-025 Reset mid-operation discards outstanding IDs; late target responses after release are violations.

Structure
REQ-026 Package instr_router_pkg holds region_cfg_t (base, mask) typedef, ERR_ID function, MAX_REGIONS = 8.
REQ-027 One sub-module: instr_router_id_fifo (depth MAX_OUTSTANDING, width clog2(NUM_REGIONS+1), occupancy counter).
REQ-028 Parameter checks SHALL error at elaboration on out-of-range NUM_REGIONS or MAX_OUTSTANDING.

Verification
REQ-029 Fetch 0x00000010, target 1 gnt, rvalid next cycle rdata 0x00000013 -> tgt_addr_o[1] 0x10, core rvalid/rdata 0x00000013, err 0.
REQ-030 Fetch 0x00040080 then 0x00000004 back-to-back, target 1 answers first -> violation set; correct order -> rdata ROM then RAM.
REQ-031 Fetch 0x80000000 -> gnt same cycle, rvalid 1 cycle later, err 1, rdata 0, no tgt_req_o.
REQ-032 Two accepted, no responses, third request -> gnt_o 0, tgt_req_o 0 until a response pops.
REQ-033 Reset asserted with 2 outstanding -> all outputs at reset values; post-release fetch completes normally.
REQ-034 Random stream 1000 fetches, random gnt/rvalid delays -> scoreboard order and data match, violation 0.
